vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receiving end of the VGA timing interface: consumes active-low hsync/vsync produced by our 640x480@60 timing generator, or by any external source, on the pixel clock.
- Recovers pixel position and display enable, measures line and frame lengths, checks sync widths, and reports lock.
- Used as a loop-back monitor in the display path and as the front end of any downstream block that must recover x/y from sync alone.

Parameters:
- H_LINE, 800, pixel clocks per line
- H_BACK, 144, sync plus back porch width in clocks (first visible h_pos)
- H_FRONT, 16, front porch width in clocks
- H_SYNC, 96, hsync low width in clocks
- V_LINE, 525, lines per frame
- V_BACK, 35, first visible line
- V_FRONT, 10, front porch width in lines
- V_SYNC, 2, vsync low width in lines

Ports:
- clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high
- vga_h_sync  in  1  hsync, active low
- vga_v_sync  in  1  vsync, active low
- x  out  10  recovered column, 0..639; 0 outside window
- y  out  10  recovered row, 0..479; 0 outside window
- display_en  out  1  high inside visible window, only while locked
- frame_start  out  1  one-clock pulse on each accepted vsync fall
- locked  out  1  timing verified against parameters
- sync_err  out  1  one-clock pulse on each detected violation
- meas_h_total  out  10  length of last completed line, saturating at 1023
- meas_v_total  out  10  line count of last completed frame, saturating at 1023
- err_cnt  out  8  saturating violation counter

Behaviour:
- Reset: all outputs 0; FSM enters SEARCH; h_pos and v_pos 0; previous-sample registers 0, so a sync held low through reset does not count as a fall.
- Edge detect: hfall = prev_h==1 && vga_h_sync==0; hrise = prev_h==0 && vga_h_sync==1; vfall is defined the same way for vga_v_sync.
- h_pos: the sample containing hfall has h_pos 0; otherwise h_pos = previous h_pos + 1, saturating at 1023.
- v_pos: increments on hfall; the sample containing both vfall and hfall sets v_pos to 0; saturates at 1023.
- On hfall: meas_h_total <= previous h_pos + 1. On accepted vfall: meas_v_total <= previous v_pos + 1.
- Latency: every output is registered, 1 clock after the input sample.
- FSM states:
  - SEARCH: wait for the first vfall coincident with hfall, then go to MEASURE.
  - MEASURE: track one full frame. At the next coincident vfall, go to LOCKED if all of the following held: every line length == H_LINE, every hsync low width == H_SYNC, vsync low width == V_SYNC lines, and frame length == V_LINE. Otherwise stay in MEASURE and restart the check.
  - LOCKED: any violation pulses sync_err, increments err_cnt (saturating at 255), drops locked in the same output cycle, and moves to MEASURE.
- Violations, counted in LOCKED only:
  - hfall with previous h_pos + 1 != H_LINE
  - h_pos reaching H_LINE without hfall (missing hsync)
  - hrise with h_pos != H_SYNC
  - vfall without a coincident hfall
  - coincident vfall with previous v_pos + 1 != V_LINE
  - v_pos reaching V_LINE without vfall
  - vsync rise not at v_pos == V_SYNC on an hfall sample
- Multiple violations in one sample produce one sync_err pulse and one err_cnt increment.
- Window: display_en = locked && H_BACK <= h_pos < H_LINE-H_FRONT && V_BACK <= v_pos < V_LINE-V_FRONT.
  - x = h_pos - H_BACK inside the horizontal window, else 0.
  - y = v_pos - V_BACK inside the vertical window, else 0.
  - x and y are computed regardless of lock.
- frame_start pulses on every coincident vfall in any state except SEARCH.
- Reset mid-frame: all state clears; lock requires a fresh SEARCH→MEASURE→LOCKED sequence of two full frames.

Decomposition:
- Shared package vga_timing_pkg holds the eight timing constants and the FSM state enum {SEARCH, MEASURE, LOCKED}. The timing generator and this decoder both import it.
- One natural sub-module: vga_edge_counter, instantiated twice (horizontal, vertical). It provides the saturating position counter, edge detect, length capture, and low-width measurement.

Test Plan:
- Nominal generator stream from reset → locked rises 1 clock after the second coincident vfall sample; meas_h_total=800, meas_v_total=525; err_cnt=0 over 3 frames.
- While locked, sample h_pos=144, v_pos=35 → next clock x=0, y=0, display_en=1; at h_pos=783, v_pos=514 → x=639, y=479; at h_pos=784 → display_en=0, x=0.
- While locked, suppress one hsync pulse → sync_err pulses once, triggered when h_pos reaches 800; locked=0, err_cnt=1; relock after two further clean frame boundaries.
- Source with a 799-clock line → never locks; meas_h_total=799; err_cnt stays 0.
- While locked, move vfall to h_pos=5 → sync_err pulse, locked=0, no frame_start for that edge.
- Assert reset at v_pos=200 for 1 clock → all outputs 0 next clock; locked=0 until two full frames later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the sync-decoder state encoding.
// Imported by the timing generator and the sync decoder.
package vga_timing_pkg;

   localparam int H_LINE  = 800;
   localparam int H_BACK  = 144;
   localparam int H_FRONT = 16;
   localparam int H_SYNC  = 96;
   localparam int V_LINE  = 525;
   localparam int V_BACK  = 35;
   localparam int V_FRONT = 10;
   localparam int V_SYNC  = 2;

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   typedef enum logic [1:0] {
      SEARCH  = ST_SEARCH,
      MEASURE = ST_MEASURE,
      LOCKED  = ST_LOCKED
   } sync_state_t;

   function automatic logic [9:0] sat_inc10(input logic [9:0] val);
      return (val == 10'h3ff) ? val : val + 10'd1;
   endfunction

endpackage

// File: rtl/vga_edge_counter.sv
// Edge detect on one active-low sync plus a saturating position counter that
// zeroes on clr_i and captures the length of the run it just ended.
module vga_edge_counter
   import vga_timing_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       sync_i,
   input  logic       step_i,
   input  logic       clr_i,
   output logic       fall_o,
   output logic       rise_o,
   output logic [9:0] pos_d_o,
   output logic [9:0] run_o,
   output logic [9:0] len_o
);

   logic       prev_q;
   logic [9:0] pos_q;
   logic [9:0] pos_d;
   logic [9:0] len_q;
   logic [9:0] len_d;

   // prev_q clears in reset so a sync held low through reset is not a fall
   assign fall_o  = prev_q & ~sync_i;
   assign rise_o  = ~prev_q & sync_i;
   assign run_o   = sat_inc10(pos_q);
   assign pos_d_o = pos_d;
   assign len_o   = len_q;

   always_comb begin
      pos_d = pos_q;
      len_d = len_q;
      if (clr_i) begin
         pos_d = '0;
         len_d = run_o;
      end else if (step_i) begin
         pos_d = run_o;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
         pos_q  <= '0;
         len_q  <= '0;
      end else begin
         prev_q <= sync_i;
         pos_q  <= pos_d;
         len_q  <= len_d;
      end
   end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers x/y, display enable and lock from active-low hsync/vsync alone.
// state   | meaning
// SEARCH  | waiting for the first vsync fall coincident with an hsync fall
// MEASURE | checking one whole frame against the timing parameters
// LOCKED  | timing verified; any violation reports and drops to MEASURE
module vga_sync_decoder #(
   parameter int H_LINE  = vga_timing_pkg::H_LINE,
   parameter int H_BACK  = vga_timing_pkg::H_BACK,
   parameter int H_FRONT = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
   parameter int V_LINE  = vga_timing_pkg::V_LINE,
   parameter int V_BACK  = vga_timing_pkg::V_BACK,
   parameter int V_FRONT = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC  = vga_timing_pkg::V_SYNC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vga_h_sync,
   input  logic       vga_v_sync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       display_en,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_err,
   output logic [9:0] meas_h_total,
   output logic [9:0] meas_v_total,
   output logic [7:0] err_cnt
);

   import vga_timing_pkg::*;

   localparam logic [9:0] H_LINE_C = 10'(H_LINE);
   localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
   localparam logic [9:0] H_BEG_C  = 10'(H_BACK);
   localparam logic [9:0] H_END_C  = 10'(H_LINE - H_FRONT);
   localparam logic [9:0] V_LINE_C = 10'(V_LINE);
   localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
   localparam logic [9:0] V_BEG_C  = 10'(V_BACK);
   localparam logic [9:0] V_END_C  = 10'(V_LINE - V_FRONT);

   logic        h_fall, h_rise, v_fall, v_rise;
   logic [9:0]  h_pos_d, v_pos_d, h_run, v_run;
   logic        coin, viol, h_in, v_in;
   sync_state_t state_q, state_d;
   logic        bad_q, bad_d, err_pulse;
   logic [9:0]  x_q, y_q, x_d, y_d;
   logic        de_q, de_d, fs_q, fs_d, lock_q, lock_d, serr_q;
   logic [7:0]  err_cnt_q, err_cnt_d;

   vga_edge_counter u_h (
      .clk     (clk),
      .reset   (reset),
      .sync_i  (vga_h_sync),
      .step_i  (1'b1),
      .clr_i   (h_fall),
      .fall_o  (h_fall),
      .rise_o  (h_rise),
      .pos_d_o (h_pos_d),
      .run_o   (h_run),
      .len_o   (meas_h_total)
   );

   vga_edge_counter u_v (
      .clk     (clk),
      .reset   (reset),
      .sync_i  (vga_v_sync),
      .step_i  (h_fall),
      .clr_i   (coin),
      .fall_o  (v_fall),
      .rise_o  (v_rise),
      .pos_d_o (v_pos_d),
      .run_o   (v_run),
      .len_o   (meas_v_total)
   );

   assign coin = h_fall & v_fall;

   // Sync widths are the position at the rising edge of the sync pulse
   assign viol = (h_fall && (h_run != H_LINE_C))
              || (h_pos_d == H_LINE_C)
              || (h_rise && (h_pos_d != H_SYNC_C))
              || (v_fall && !h_fall)
              || (coin && (v_run != V_LINE_C))
              || (h_fall && (v_pos_d == V_LINE_C))
              || (v_rise && !(h_fall && (v_pos_d == V_SYNC_C)));

   always_comb begin
      state_d   = state_q;
      bad_d     = bad_q;
      err_pulse = 1'b0;
      case (state_q)
         SEARCH: begin
            if (coin) begin
               state_d = MEASURE;
               bad_d   = 1'b0;
            end
         end
         MEASURE: begin
            if (coin) begin
               if (!bad_q && !viol) state_d = LOCKED;
               bad_d = 1'b0;
            end else if (viol) begin
               bad_d = 1'b1;
            end
         end
         LOCKED: begin
            if (viol) begin
               state_d   = MEASURE;
               // the interrupted frame is partial, so it must not count as clean
               bad_d     = 1'b1;
               err_pulse = 1'b1;
            end
         end
         default: begin
            state_d = SEARCH;
            bad_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      h_in      = (h_pos_d >= H_BEG_C) && (h_pos_d < H_END_C);
      v_in      = (v_pos_d >= V_BEG_C) && (v_pos_d < V_END_C);
      x_d       = h_in ? (h_pos_d - H_BEG_C) : 10'd0;
      y_d       = v_in ? (v_pos_d - V_BEG_C) : 10'd0;
      lock_d    = (state_d == LOCKED);
      de_d      = lock_d && h_in && v_in;
      fs_d      = coin && (state_q != SEARCH);
      err_cnt_d = (err_pulse && (err_cnt_q != 8'hff)) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SEARCH;
         bad_q     <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         de_q      <= 1'b0;
         fs_q      <= 1'b0;
         lock_q    <= 1'b0;
         serr_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bad_q     <= bad_d;
         x_q       <= x_d;
         y_q       <= y_d;
         de_q      <= de_d;
         fs_q      <= fs_d;
         lock_q    <= lock_d;
         serr_q    <= err_pulse;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign display_en  = de_q;
   assign frame_start = fs_q;
   assign locked      = lock_q;
   assign sync_err    = serr_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder: a reduced-size timing generator
// drives the decoder and a scoreboard queue holds the expected outputs.
module tb_vga_sync_decoder;

   localparam int H_LINE  = 64;
   localparam int H_BACK  = 16;
   localparam int H_FRONT = 8;
   localparam int H_SYNC  = 8;
   localparam int V_LINE  = 24;
   localparam int V_BACK  = 4;
   localparam int V_FRONT = 2;
   localparam int V_SYNC  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vga_h_sync = 1'b1;
   logic       vga_v_sync = 1'b1;
   logic [9:0] x, y, meas_h_total, meas_v_total;
   logic       display_en, frame_start, locked, sync_err;
   logic [7:0] err_cnt;

   always #5 clk = ~clk;

   vga_sync_decoder #(
      .H_LINE (H_LINE), .H_BACK (H_BACK), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC),
      .V_LINE (V_LINE), .V_BACK (V_BACK), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .vga_h_sync   (vga_h_sync),
      .vga_v_sync   (vga_v_sync),
      .x            (x),
      .y            (y),
      .display_en   (display_en),
      .frame_start  (frame_start),
      .locked       (locked),
      .sync_err     (sync_err),
      .meas_h_total (meas_h_total),
      .meas_v_total (meas_v_total),
      .err_cnt      (err_cnt)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_steps = 0;

   // generator position and fault injection
   int   gx = 0;
   int   gy = 0;
   int   glen = H_LINE;
   logic kill = 1'b0;
   logic vshift = 1'b0;
   // expected lock progress: 0 search, 1 restart pending, 2 measuring, 3 locked
   int   stage = 0;
   logic prev_hs = 1'b0;
   logic prev_vs = 1'b0;
   logic [7:0] exp_err = 8'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s sample=%0d got=%0h expected=%0h", tag, n_steps, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         0:       return {20'd0, err_cnt, sync_err, frame_start, locked, display_en};
         1:       return {12'd0, x, y};
         2:       return {22'd0, meas_h_total};
         default: return {22'd0, meas_v_total};
      endcase
   endfunction

   function automatic void push(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endfunction

   task automatic step(input logic rst);
      logic hs, vs, hf, vf, bnd, fault, fs, er, lk, de, hin, vin;
      logic [9:0] ex, ey;
      exp_t e;
      hs = kill ? 1'b1 : (gx >= H_SYNC);
      vs = vshift ? 1'b1 : (gy >= V_SYNC);
      vga_h_sync = hs;
      vga_v_sync = vs;
      reset = rst;
      if (rst) begin
         stage = 0;
         exp_err = 8'd0;
         prev_hs = 1'b0;
         prev_vs = 1'b0;
         push("rst_status", 0, 32'd0);
         push("rst_xy", 1, 32'd0);
         push("rst_meas_h", 2, 32'd0);
         push("rst_meas_v", 3, 32'd0);
      end else begin
         hf = prev_hs & ~hs;
         vf = prev_vs & ~vs;
         bnd = hf & vf;
         fault = (stage == 3) && (gx == 0) && (kill || (vshift && gy == 0));
         fs = 1'b0;
         er = 1'b0;
         if (fault) begin
            er = 1'b1;
            stage = 1;
            if (exp_err != 8'hff) exp_err = exp_err + 8'd1;
         end else if (bnd) begin
            fs = (stage != 0);
            if (stage < 2) stage = 2;
            else if (stage == 2 && glen == H_LINE) stage = 3;
         end
         lk  = (stage == 3);
         hin = (gx >= H_BACK) && (gx < H_LINE - H_FRONT);
         vin = (gy >= V_BACK) && (gy < V_LINE - V_FRONT);
         ex  = hin ? 10'(gx - H_BACK) : 10'd0;
         ey  = vin ? 10'(gy - V_BACK) : 10'd0;
         de  = lk && hin && vin;
         push("status", 0, {20'd0, exp_err, er, fs, lk, de});
         if (stage >= 2 && glen == H_LINE) push("xy", 1, {12'd0, ex, ey});
         if (lk && gx == H_BACK && gy == V_BACK) push("win_first", 1, 32'd0);
         if (lk && gx == H_LINE - H_FRONT - 1 && gy == V_LINE - V_FRONT - 1)
            push("win_last", 1, {12'd0, 10'(H_LINE - H_FRONT - 1 - H_BACK), 10'(V_LINE - V_FRONT - 1 - V_BACK)});
         prev_hs = hs;
         prev_vs = vs;
      end
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, obs(e.sel), e.exp);
      end
      n_steps++;
      gx++;
      if (gx >= glen) begin
         gx = 0;
         gy++;
         if (gy >= V_LINE) gy = 0;
      end
   endtask

   task automatic run_frames(input int n);
      repeat (n * glen * V_LINE) step(1'b0);
   endtask

   task automatic run_until(input int tx, input int ty);
      int guard;
      guard = 0;
      while (!(gx == tx && gy == ty) && guard < 2 * H_LINE * V_LINE) begin
         step(1'b0);
         guard++;
      end
   endtask

   task automatic expect_meas(input int h, input int v);
      push("meas_h", 2, 32'(h));
      push("meas_v", 3, 32'(v));
   endtask

   initial begin
      // nominal stream from reset: lock on the second coincident boundary
      repeat (3) step(1'b1);
      gx = 0;
      gy = 0;
      run_frames(4);
      expect_meas(H_LINE, V_LINE);
      step(1'b0);

      // suppressed hsync on line 5 while locked
      run_until(0, 5);
      kill = 1'b1;
      repeat (H_LINE) step(1'b0);
      kill = 1'b0;
      run_frames(3);
      check_val("relock_after_hmiss", {31'd0, locked}, 32'd1);

      // vsync fall moved five clocks into the line
      run_until(0, 0);
      vshift = 1'b1;
      repeat (5) step(1'b0);
      vshift = 1'b0;
      run_frames(3);
      check_val("err_cnt_two", {24'd0, err_cnt}, 32'd2);

      // one-clock reset in mid frame
      run_until(20, 10);
      step(1'b1);
      run_frames(3);
      expect_meas(H_LINE, V_LINE);
      step(1'b0);

      // source one clock short per line never locks
      repeat (2) step(1'b1);
      gx = 0;
      gy = 0;
      glen = H_LINE - 1;
      run_frames(4);
      expect_meas(H_LINE - 1, V_LINE);
      step(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
